// File: rtl/rf_loader.sv
// Byte-stream register-file loader: assembles little-endian byte pairs into
// 16-bit words and writes them to consecutive registers starting at FIRST_REG.
module rf_loader #(
  parameter int REGBITS   = 3,
  parameter int FIRST_REG = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               rf_wr_en,
  output logic [REGBITS-1:0] rf_addr,
  output logic [15:0]        rf_wr_data,
  output logic [4:0]         rf_flags,
  output logic               busy,
  output logic               done,
  output logic [2:0]         dbg_state
);

  // Handshake: a byte moves on a rising edge only when in_valid and in_ready
  // are both high; in_ready is a pure decode of the state, so it never depends
  // combinationally on in_valid.
  typedef enum logic [2:0] {IDLE, LO, HI, WRITE, DONE} state_t;

  localparam logic [REGBITS-1:0] LAST_ADDR  = '1;
  localparam logic [REGBITS-1:0] FIRST_ADDR = REGBITS'(FIRST_REG);

  state_t     state, state_next;
  logic [7:0] lo_q;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start && !abort) state_next = LO;
      LO:      if (abort) state_next = IDLE;
               else if (in_valid) state_next = HI;
      HI:      if (abort) state_next = IDLE;
               else if (in_valid) state_next = WRITE;
      WRITE:   if (abort) state_next = IDLE;
               else if (rf_addr == LAST_ADDR) state_next = DONE;
               else state_next = LO;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rf_addr    <= '0;
      rf_wr_data <= '0;
      lo_q       <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE:  if (start && !abort) rf_addr <= FIRST_ADDR;
        LO:    if (!abort && in_valid) lo_q <= in_data;
        // The word is latched as WRITE is entered so it is stable during the strobe.
        HI:    if (!abort && in_valid) rf_wr_data <= {in_data, lo_q};
        WRITE: if (!abort && rf_addr != LAST_ADDR) rf_addr <= rf_addr + REGBITS'(1);
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == LO) || (state == HI);
  assign rf_wr_en  = (state == WRITE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign rf_flags  = 5'b0;
  assign dbg_state = state;

endmodule

// File: tb/tb_rf_loader.sv
// Bench for rf_loader: byte-queue driver, scoreboard monitors for two
// configurations (REGBITS=3 and REGBITS=2), scenario tasks, one summary line.
module tb_rf_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        rf_wr_en;
  logic [2:0]  rf_addr;
  logic [15:0] rf_wr_data;
  logic [4:0]  rf_flags;
  logic        busy;
  logic        done;
  logic [2:0]  dbg_state;

  logic        start2;
  logic [7:0]  in_data2;
  logic        in_valid2;
  logic        in_ready2;
  logic        rf_wr_en2;
  logic [1:0]  rf_addr2;
  logic [15:0] rf_wr_data2;
  logic [4:0]  rf_flags2;
  logic        busy2;
  logic        done2;
  logic [2:0]  dbg_state2;

  int total = 0;
  int bad   = 0;

  logic [7:0]  byte_q[$];
  logic        src_en;
  logic        xfer;
  logic [18:0] exp_q[$];
  logic [17:0] exp2_q[$];

  rf_loader #(.REGBITS(3), .FIRST_REG(1)) u_dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .rf_wr_en(rf_wr_en), .rf_addr(rf_addr), .rf_wr_data(rf_wr_data),
    .rf_flags(rf_flags), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  rf_loader #(.REGBITS(2), .FIRST_REG(1)) u_dut2 (
    .clk(clk), .reset(reset), .start(start2), .abort(abort),
    .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
    .rf_wr_en(rf_wr_en2), .rf_addr(rf_addr2), .rf_wr_data(rf_wr_data2),
    .rf_flags(rf_flags2), .busy(busy2), .done(done2), .dbg_state(dbg_state2)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- byte stream driver ----------------
  task automatic refresh();
    in_valid = src_en && (byte_q.size() != 0);
    in_data  = (byte_q.size() != 0) ? byte_q[0] : 8'($urandom_range(0, 255));
  endtask

  always @(negedge clk) begin
    #4;
    xfer = in_valid && in_ready;
  end

  always @(posedge clk) begin
    #1;
    if (xfer && byte_q.size() != 0) void'(byte_q.pop_front());
    xfer = 1'b0;
    refresh();
  end

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk) begin
    if (rf_wr_en === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write addr=%0d data=%h", rf_addr, rf_wr_data);
      end else begin
        logic [18:0] e;
        e = exp_q.pop_front();
        if ({rf_addr, rf_wr_data} !== e) begin
          bad++;
          $display("FAIL write got addr=%0d data=%h exp addr=%0d data=%h",
                   rf_addr, rf_wr_data, e[18:16], e[15:0]);
        end
      end
      total++;
      if (rf_flags !== 5'b0) begin
        bad++;
        $display("FAIL rf_flags got=%b exp=00000", rf_flags);
      end
    end
  end

  always @(negedge clk) begin
    if (rf_wr_en2 === 1'b1) begin
      total++;
      if (exp2_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write2 addr=%0d data=%h", rf_addr2, rf_wr_data2);
      end else begin
        logic [17:0] e;
        e = exp2_q.pop_front();
        if ({rf_addr2, rf_wr_data2} !== e) begin
          bad++;
          $display("FAIL write2 got addr=%0d data=%h exp addr=%0d data=%h",
                   rf_addr2, rf_wr_data2, e[17:16], e[15:0]);
        end
      end
    end
  end

  // ---------------- helpers ----------------
  // Queues n random words; only the first n_exp are expected to be written.
  task automatic preload_random(input int n, input int n_exp);
    logic [7:0] lo, hi;
    for (int i = 1; i <= n; i++) begin
      lo = 8'($urandom_range(0, 255));
      hi = 8'($urandom_range(0, 255));
      byte_q.push_back(lo);
      byte_q.push_back(hi);
      if (i <= n_exp) exp_q.push_back({3'(i), hi, lo});
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask

  task automatic check_drained(input string name);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s pending_writes got=%0d exp=0", name, exp_q.size());
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    start = 1'b1;
    @(negedge clk);
    total++;
    if ({rf_wr_en, in_ready, busy, done, rf_addr, rf_wr_data, rf_flags} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=0",
               {rf_wr_en, in_ready, busy, done, rf_addr, rf_wr_data, rf_flags});
    end
    total++;
    if ({rf_wr_en2, in_ready2, busy2, done2, rf_addr2, rf_wr_data2} !== '0) begin
      bad++;
      $display("FAIL reset_outputs2 got=%h exp=0",
               {rf_wr_en2, in_ready2, busy2, done2, rf_addr2, rf_wr_data2});
    end
    start = 1'b0;
  endtask

  task automatic test_full_load();
    byte_q.delete();
    for (int i = 1; i <= 7; i++) begin
      byte_q.push_back(8'(i));
      byte_q.push_back(8'h00);
      exp_q.push_back({3'(i), 16'(i)});
    end
    src_en = 1'b1;
    refresh();
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      start = 1'b0;
      check_bit($sformatf("full_wr_en_c%0d", k), rf_wr_en, (k % 3 == 0) && (k <= 21));
      check_bit($sformatf("full_done_c%0d", k), done, k == 22);
      check_bit($sformatf("full_busy_c%0d", k), busy, k <= 22);
    end
    check_drained("full_load");
    src_en = 1'b0;
  endtask

  task automatic test_stall();
    byte_q.delete();
    byte_q.push_back(8'hCD);
    exp_q.push_back({3'd1, 16'hABCD});
    src_en = 1'b1;
    refresh();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 5; s++) begin
      check_bit($sformatf("stall_in_ready_%0d", s), in_ready, 1'b1);
      check_bit($sformatf("stall_in_valid_%0d", s), in_valid, 1'b0);
      @(negedge clk);
    end
    byte_q.push_back(8'hAB);
    refresh();
    @(negedge clk);
    check_bit("stall_wr_en", rf_wr_en, 1'b1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_bit("stall_abort_busy", busy, 1'b0);
    check_bit("stall_abort_done", done, 1'b0);
    check_drained("stall");
    src_en = 1'b0;
  endtask

  task automatic test_abort();
    byte_q.delete();
    byte_q.push_back(8'h34);
    src_en = 1'b1;
    refresh();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check_bit("abort_hi_in_ready", in_ready, 1'b1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_bit("abort_hi_busy", busy, 1'b0);
    check_bit("abort_hi_in_ready_low", in_ready, 1'b0);
    repeat (3) @(negedge clk);
    check_bit("abort_hi_still_idle", busy, 1'b0);

    // Restart reloads r1; abort in WRITE still lets that write through.
    byte_q.delete();
    preload_random(1, 1);
    refresh();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check_bit("restart_wr_en", rf_wr_en, 1'b1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_bit("abort_write_busy", busy, 1'b0);
    check_bit("abort_write_done", done, 1'b0);
    check_drained("abort_write");

    // Simultaneous start and abort in IDLE: abort wins.
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check_bit("start_abort_busy", busy, 1'b0);
    check_bit("start_abort_in_ready", in_ready, 1'b0);
    src_en = 1'b0;
  endtask

  task automatic test_start_while_busy();
    int writes;
    writes = 0;
    byte_q.delete();
    preload_random(7, 7);
    src_en = 1'b1;
    refresh();
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (rf_wr_en === 1'b1) writes++;
      if (k == 22) check_bit("busy_start_done", done, 1'b1);
      start = (k == 4 || k == 10 || k == 17 || k == 22);
    end
    start = 1'b0;
    total++;
    if (writes != 7) begin
      bad++;
      $display("FAIL busy_start_writes got=%0d exp=7", writes);
    end
    check_bit("busy_start_idle", busy, 1'b0);
    check_drained("start_while_busy");
    src_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    byte_q.delete();
    preload_random(7, 3);
    src_en = 1'b1;
    refresh();
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check_bit("mid_r3_write", rf_wr_en, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if ({rf_wr_en, in_ready, busy, done, rf_addr, rf_wr_data} !== '0) begin
      bad++;
      $display("FAIL mid_reset_outputs got=%h exp=0",
               {rf_wr_en, in_ready, busy, done, rf_addr, rf_wr_data});
    end
    byte_q.delete();
    src_en = 1'b0;
    refresh();
    repeat (10) @(negedge clk);
    check_bit("mid_reset_idle", busy, 1'b0);
    check_drained("reset_mid");
  endtask

  task automatic test_regbits2();
    logic [7:0] b, lo;
    lo = 8'h00;
    @(negedge clk);
    start2 = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      start2 = 1'b0;
      check_bit($sformatf("rb2_wr_en_c%0d", k), rf_wr_en2, (k % 3 == 0) && (k <= 9));
      check_bit($sformatf("rb2_done_c%0d", k), done2, k == 10);
      if (k <= 10) begin
        total++;
        if (rf_addr2 === 2'd0) begin
          bad++;
          $display("FAIL rb2_addr_zero_c%0d got=%0d exp=nonzero", k, rf_addr2);
        end
      end
      b = 8'($urandom_range(0, 255));
      in_data2 = b;
      if (k <= 9 && k % 3 == 1) lo = b;
      if (k <= 9 && k % 3 == 2) exp2_q.push_back({2'(k / 3 + 1), b, lo});
    end
    total++;
    if (exp2_q.size() != 0) begin
      bad++;
      $display("FAIL rb2 pending_writes got=%0d exp=0", exp2_q.size());
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    start2    = 1'b0;
    in_data2  = 8'h00;
    in_valid2 = 1'b1;
    src_en    = 1'b0;
    xfer      = 1'b0;
    refresh();
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b0;
    @(negedge clk);
    test_full_load();
    test_stall();
    test_abort();
    test_start_while_busy();
    test_reset_mid();
    test_regbits2();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
